// File: rtl/snake_ptn_gen_if.sv
// Control and display bundle for the snake pattern generator.
// The master drives en/run_stop; the slave (generator) drives position, direction, step, segments and done.
interface snake_ptn_gen_if;
  logic       en;
  logic       run_stop;
  logic [4:0] ptn_cnt;
  logic       updn;
  logic       step;
  logic [6:0] seg;
  logic       done;

  modport master (
    output en,
    output run_stop,
    input  ptn_cnt,
    input  updn,
    input  step,
    input  seg,
    input  done
  );

  modport slave (
    input  en,
    input  run_stop,
    output ptn_cnt,
    output updn,
    output step,
    output seg,
    output done
  );
endinterface

// File: rtl/snake_ptn_gen.sv
// Bouncing "snake" position generator driving a 7-segment digit; one step every TICK_DIV enabled cycles.
// All outputs registered (seg/step change on the same edge as ptn_cnt); en low pauses, run_stop halts until reset.
module snake_ptn_gen #(
  parameter int CNT_LENGTH = 8,
  parameter int TICK_DIV   = 25000000
) (
  input logic            clk,
  input logic            rst,
  snake_ptn_gen_if.slave bus
);

  localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]     CNT_LAST  = 5'(CNT_LENGTH - 1);
  localparam logic [6:0]     SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          updn_q, updn_d;
  logic          step_q, step_d;
  logic [6:0]    seg_q, seg_d;
  logic          done_q, done_d;

  // Segment chase order {g,f,e,d,c,b,a}, active low: a, b, g, e, d, c, g, f.
  function automatic logic [6:0] seg_of(input logic [2:0] pos);
    logic [6:0] s;
    case (pos)
      3'd0:    s = 7'b1111110;
      3'd1:    s = 7'b1111101;
      3'd2:    s = 7'b0111111;
      3'd3:    s = 7'b1101111;
      3'd4:    s = 7'b1110111;
      3'd5:    s = 7'b1111011;
      3'd6:    s = 7'b0111111;
      default: s = 7'b1011111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    updn_d  = updn_q;
    step_d  = 1'b0;
    seg_d   = seg_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        seg_d  = SEG_OFF;
        if (bus.en) begin
          state_d = RUN;
          tick_d  = '0;
          cnt_d   = 5'd0;
          updn_d  = 1'b1;
          seg_d   = seg_of(3'd0);
        end
      end

      RUN: begin
        // Halt wins over a coincident step so the frozen position is the pre-halt one.
        if (bus.run_stop) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (bus.en) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            step_d = 1'b1;
            if (updn_q) begin
              if (cnt_q >= CNT_LAST) begin
                cnt_d  = CNT_LAST - 5'd1;
                updn_d = 1'b0;
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end else begin
              if (cnt_q == 5'd0) begin
                cnt_d  = 5'd1;
                updn_d = 1'b1;
              end else begin
                cnt_d = cnt_q - 5'd1;
              end
            end
            seg_d = seg_of(cnt_d[2:0]);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      HALT: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      cnt_q   <= 5'd0;
      updn_q  <= 1'b1;
      step_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      updn_q  <= updn_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end

  assign bus.ptn_cnt = cnt_q;
  assign bus.updn    = updn_q;
  assign bus.step    = step_q;
  assign bus.seg     = seg_q;
  assign bus.done    = done_q;

endmodule
